sum_latch_uart_tx: RTL and testbench

SUM_LATCH_UART_TX -- requirements
Module: sum_latch_uart_tx

---
 rtl/sum_latch_pkg.sv | 23 ++
 rtl/sum_latch_uart_tx_core.sv | 63 ++++++
 rtl/sum_latch_uart_tx.sv | 181 ++++++++++++++++++
 tb/tb_sum_latch_uart_tx.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sum_latch_pkg.sv
// Shared types and constants for the operand-sum UART transmitter.
package sum_latch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_BYTE,
        SEND,
        NEXT
    } state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int unsigned FRAME_BITS = 10;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Nibble to uppercase ASCII hex digit.
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + 8'(nib)) : (8'h37 + 8'(nib));
    endfunction

endpackage

// File: rtl/sum_latch_uart_tx_core.sv
// 8N1 byte serializer; byte_ready_c rises in the final stop-bit cycle so frames chain with no gap.
module uart_tx_core
    import sum_latch_pkg::*;
#(
    parameter int unsigned CLK_DIV = 104
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready_c,
    output logic       txd
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [3:0] BIT_LAST = 4'(FRAME_BITS - 1);
    localparam logic [3:0] BIT_DATA_LAST = 4'(FRAME_BITS - 2);

    logic             active;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       bit_idx;
    logic [7:0]       shreg;
    logic             bit_end;

    assign bit_end      = (cnt == CNT_LAST);
    assign byte_ready_c = !active || (bit_end && (bit_idx == BIT_LAST));

    always_ff @(posedge clk) begin
        if (reset) begin
            active  <= 1'b0;
            txd     <= STOP_BIT;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else if (byte_valid && byte_ready_c) begin
            active  <= 1'b1;
            txd     <= START_BIT;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= byte_data;
        end else if (active) begin
            if (bit_end) begin
                cnt <= '0;
                if (bit_idx == BIT_LAST) begin
                    active <= 1'b0;
                    txd    <= STOP_BIT;
                end else begin
                    bit_idx <= bit_idx + 4'd1;
                    if (bit_idx == BIT_DATA_LAST) begin
                        txd <= STOP_BIT;
                    end else begin
                        txd   <= shreg[0];
                        shreg <= {1'b0, shreg[7:1]};
                    end
                end
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/sum_latch_uart_tx.sv
// Latches NUM_OPS operands from a shared bus and transmits their sum over UART as raw bytes or hex text.
module sum_latch_uart_tx
    import sum_latch_pkg::*;
#(
    parameter int unsigned DATA_W  = 3,
    parameter int unsigned NUM_OPS = 2,
    parameter int unsigned CLK_DIV = 104,
    parameter int unsigned MODE    = 0,
    localparam int unsigned SUM_W  = DATA_W + $clog2(NUM_OPS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_OPS-1:0] save_n,
    input  logic [DATA_W-1:0]  data_in,
    input  logic               tx_en,
    output logic               uart_txd,
    output logic               uart_tx_busy,
    output logic [SUM_W-1:0]   sum_out,
    output logic               sum_valid
);

    localparam int unsigned N_DIGITS = (SUM_W + 3) / 4;
    localparam int unsigned N_BYTES  = (MODE == 0) ? (SUM_W + 7) / 8 : N_DIGITS + 2;
    localparam int unsigned PAD_W    = 8 * N_BYTES;
    localparam int unsigned IDX_W    = 4;

    if (DATA_W < 1 || DATA_W > 8 || NUM_OPS < 2 || NUM_OPS > 4 || CLK_DIV < 2 || MODE > 1)
    begin : g_param_check
        $error("sum_latch_uart_tx: parameter out of range");
    end

    logic [NUM_OPS-1:0] save_s1, save_s2, save_s3;
    logic [DATA_W-1:0]  data_s1, data_s2;
    logic [NUM_OPS-1:0] fall;
    logic [DATA_W-1:0]  ops [NUM_OPS];
    logic [NUM_OPS-1:0] loaded;
    logic [SUM_W-1:0]   sum_c;

    state_t             state, state_d;
    logic [IDX_W-1:0]   idx, idx_d;
    logic               pend, pend_d;
    logic [7:0]         hold, hold_d;
    logic               start_c;
    logic               tx_valid_c;
    logic [7:0]         tx_data_c;
    logic               tx_ready_c;

    // Message byte idx for a given sum value.
    function automatic logic [7:0] msg_byte(input logic [SUM_W-1:0] v, input logic [IDX_W-1:0] i);
        logic [PAD_W-1:0] p;
        logic [7:0]       r;
        int unsigned      nb;
        p = PAD_W'(v);
        r = 8'h00;
        for (int unsigned b = 0; b < N_BYTES; b++) begin
            nb = (b < N_DIGITS) ? (N_DIGITS - 1 - b) : 0;
            if (i == IDX_W'(b)) begin
                if (MODE == 0)         r = p[8*b +: 8];
                else if (b < N_DIGITS) r = hex_ascii(p[4*nb +: 4]);
                else if (b == N_DIGITS) r = ASCII_CR;
                else                   r = ASCII_LF;
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            save_s1 <= '1;
            save_s2 <= '1;
            save_s3 <= '1;
            data_s1 <= '0;
            data_s2 <= '0;
        end else begin
            save_s1 <= save_n;
            save_s2 <= save_s1;
            save_s3 <= save_s2;
            data_s1 <= data_in;
            data_s2 <= data_s1;
        end
    end

    assign fall = save_s3 & ~save_s2;

    // A strobe landing in the start cycle is kept for the next message.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_OPS; i++) ops[i] <= '0;
            loaded <= '0;
        end else begin
            for (int i = 0; i < NUM_OPS; i++) begin
                if (fall[i]) ops[i] <= data_s2;
            end
            loaded <= (start_c ? '0 : loaded) | fall;
        end
    end

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < NUM_OPS; i++) sum_c = sum_c + SUM_W'(ops[i]);
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    // First byte goes straight from the live sum so the start bit leads by one cycle.
    always_comb begin
        state_d    = state;
        idx_d      = idx;
        pend_d     = pend;
        hold_d     = hold;
        start_c    = 1'b0;
        tx_valid_c = 1'b0;
        tx_data_c  = hold;
        case (state)
            IDLE: begin
                if ((&loaded) && tx_en && tx_ready_c) begin
                    start_c    = 1'b1;
                    tx_valid_c = 1'b1;
                    tx_data_c  = msg_byte(sum_c, '0);
                    idx_d      = IDX_W'(1);
                    state_d    = NEXT;
                end
            end
            NEXT: begin
                if (idx == IDX_W'(N_BYTES)) state_d = SEND;
                else                        state_d = LOAD_BYTE;
            end
            LOAD_BYTE: begin
                hold_d  = msg_byte(sum_out, idx);
                pend_d  = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                tx_valid_c = pend;
                if (tx_ready_c) begin
                    if (pend) begin
                        idx_d   = idx + IDX_W'(1);
                        pend_d  = 1'b0;
                        state_d = NEXT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx          <= '0;
            pend         <= 1'b0;
            hold         <= '0;
            sum_out      <= '0;
            sum_valid    <= 1'b0;
            uart_tx_busy <= 1'b0;
        end else begin
            idx          <= idx_d;
            pend         <= pend_d;
            hold         <= hold_d;
            sum_valid    <= start_c;
            uart_tx_busy <= (state_d != IDLE);
            if (start_c) sum_out <= sum_c;
        end
    end

    uart_tx_core #(
        .CLK_DIV(CLK_DIV)
    ) u_core (
        .clk         (clk),
        .reset       (reset),
        .byte_data   (tx_data_c),
        .byte_valid  (tx_valid_c),
        .byte_ready_c(tx_ready_c),
        .txd         (uart_txd)
    );

endmodule

// File: tb/tb_sum_latch_uart_tx.sv
// Scoreboard bench: three configurations (raw 3x2, hex 3x2, raw 8x4) decoded from uart_txd.
module tb_sum_latch_uart_tx;

    localparam int DIV = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [1:0] save0, save1;
    logic [3:0] save2;
    logic [2:0] data0, data1;
    logic [7:0] data2;
    logic [2:0] en;
    wire  [2:0] txd, busy, vld;
    wire  [3:0] sum0, sum1;
    wire  [9:0] sum2;

    sum_latch_uart_tx #(.DATA_W(3), .NUM_OPS(2), .CLK_DIV(DIV), .MODE(0)) u_raw (
        .clk(clk), .reset(reset), .save_n(save0), .data_in(data0), .tx_en(en[0]),
        .uart_txd(txd[0]), .uart_tx_busy(busy[0]), .sum_out(sum0), .sum_valid(vld[0]));

    sum_latch_uart_tx #(.DATA_W(3), .NUM_OPS(2), .CLK_DIV(DIV), .MODE(1)) u_hex (
        .clk(clk), .reset(reset), .save_n(save1), .data_in(data1), .tx_en(en[1]),
        .uart_txd(txd[1]), .uart_tx_busy(busy[1]), .sum_out(sum1), .sum_valid(vld[1]));

    sum_latch_uart_tx #(.DATA_W(8), .NUM_OPS(4), .CLK_DIV(DIV), .MODE(0)) u_wide (
        .clk(clk), .reset(reset), .save_n(save2), .data_in(data2), .tx_en(en[2]),
        .uart_txd(txd[2]), .uart_tx_busy(busy[2]), .sum_out(sum2), .sum_valid(vld[2]));

    logic [7:0] exp_q[$];
    int         sum_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         busy_cnt[3] = '{0, 0, 0};
    int         vld_cnt[3]  = '{0, 0, 0};

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            busy_cnt[i] <= busy_cnt[i] + ((busy[i] === 1'b1) ? 1 : 0);
            vld_cnt[i]  <= vld_cnt[i] + ((vld[i] === 1'b1) ? 1 : 0);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, required finish before 300000");
        $fatal(1);
    end

    // Reference encoding of a message for instance sel.
    task automatic push_msg(input int sel, input int sum);
        int sw, nd, d;
        sw = (sel == 2) ? 10 : 4;
        sum_q.push_back(sum);
        if (sel != 1) begin
            for (int j = 0; j < (sw + 7) / 8; j++) exp_q.push_back(8'((sum >> (8 * j)) & 255));
        end else begin
            nd = (sw + 3) / 4;
            for (int j = 0; j < nd; j++) begin
                d = (sum >> (4 * (nd - 1 - j))) & 15;
                exp_q.push_back((d < 10) ? 8'(48 + d) : 8'(55 + d));
            end
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endtask

    task automatic latch(input int sel, input int mask, input int value, input int hold);
        @(negedge clk);
        case (sel)
            0:       begin data0 = 3'(value); save0 = ~2'(mask); end
            1:       begin data1 = 3'(value); save1 = ~2'(mask); end
            default: begin data2 = 8'(value); save2 = ~4'(mask); end
        endcase
        repeat (hold) @(negedge clk);
        save0 = '1;
        save1 = '1;
        save2 = '1;
    endtask

    // Capture one frame, sampling every cycle; ok requires uniform bit windows and correct framing.
    task automatic rx_frame(input int sel, output logic [7:0] b, output int gap, output bit ok);
        logic [9:0] fb;
        logic       s;
        gap = 0;
        ok  = 1'b1;
        fb  = '0;
        b   = '0;
        while (txd[sel] !== 1'b0 && gap < 200) begin
            @(negedge clk);
            gap++;
        end
        if (gap >= 200) begin
            ok = 1'b0;
            return;
        end
        for (int c = 0; c < 10 * DIV; c++) begin
            s = txd[sel];
            if (c % DIV == 0) fb[c / DIV] = s;
            else if (s !== fb[c / DIV]) ok = 1'b0;
            @(negedge clk);
        end
        if (fb[0] !== 1'b0 || fb[9] !== 1'b1) ok = 1'b0;
        b = fb[8:1];
    endtask

    task automatic wait_start(input int sel);
        int t = 0;
        while (txd[sel] !== 1'b0 && t < 200) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        save0 = '1; save1 = '1; save2 = '1;
        data0 = '0; data1 = '0; data2 = '0;
        en    = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (txd[i] !== 1'b1) begin n_err++; $display("FAIL reset_txd[%0d]: got %b, expected 1", i, txd[i]); end
            n_cmp++;
            if (busy[i] !== 1'b0) begin n_err++; $display("FAIL reset_busy[%0d]: got %b, expected 0", i, busy[i]); end
            n_cmp++;
            if (vld[i] !== 1'b0) begin n_err++; $display("FAIL reset_valid[%0d]: got %b, expected 0", i, vld[i]); end
        end
        n_cmp++;
        if (sum0 !== 4'd0 || sum1 !== 4'd0 || sum2 !== 10'd0) begin
            n_err++; $display("FAIL reset_sum: got %h %h %h, expected 0 0 0", sum0, sum1, sum2);
        end
        reset = 1'b0;
        en    = '1;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (busy !== 3'b000) begin n_err++; $display("FAIL reset_idle: busy %b, expected 000", busy); end
    endtask

    task automatic test_raw_frame();
        logic [7:0] b;
        int gap, v0;
        bit ok;
        latch(0, 1, 5, 1);
        push_msg(0, 11);
        v0 = vld_cnt[0];
        latch(0, 2, 6, 1);
        rx_frame(0, b, gap, ok);
        n_cmp++;
        if (!ok || b !== exp_q[0]) begin
            n_err++; $display("FAIL raw_byte: got %h ok=%0d, expected %h", b, ok, exp_q[0]);
        end
        void'(exp_q.pop_front());
        n_cmp++;
        if (busy[0] !== 1'b0 || txd[0] !== 1'b1) begin
            n_err++; $display("FAIL raw_busy_fall: busy=%b txd=%b, expected 0 1", busy[0], txd[0]);
        end
        n_cmp++;
        if (sum0 !== 4'(sum_q[0])) begin n_err++; $display("FAIL raw_sum: got %0d, expected %0d", sum0, sum_q[0]); end
        void'(sum_q.pop_front());
        n_cmp++;
        if (vld_cnt[0] - v0 !== 1) begin n_err++; $display("FAIL raw_valid_pulses: got %0d, expected 1", vld_cnt[0] - v0); end
    endtask

    task automatic test_hex_mode();
        logic [7:0] b;
        int gap, bc;
        bit ok;
        latch(1, 1, 5, 1);
        push_msg(1, 11);
        bc = busy_cnt[1];
        latch(1, 2, 6, 1);
        for (int j = 0; j < 3; j++) begin
            rx_frame(1, b, gap, ok);
            n_cmp++;
            if (!ok || b !== exp_q[0] || (j > 0 && gap != 0)) begin
                n_err++; $display("FAIL hex_byte%0d: got %h ok=%0d gap=%0d, expected %h gap 0", j, b, ok, gap, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy_cnt[1] - bc !== 120) begin n_err++; $display("FAIL hex_busy_cycles: got %0d, expected 120", busy_cnt[1] - bc); end
        n_cmp++;
        if (sum1 !== 4'(sum_q[0])) begin n_err++; $display("FAIL hex_sum: got %0d, expected %0d", sum1, sum_q[0]); end
        void'(sum_q.pop_front());
    endtask

    task automatic test_wide_sum();
        logic [7:0] b;
        int gap;
        bit ok;
        push_msg(2, 1020);
        latch(2, 15, 255, 1);
        for (int j = 0; j < 2; j++) begin
            rx_frame(2, b, gap, ok);
            n_cmp++;
            if (!ok || b !== exp_q[0] || (j > 0 && gap != 0)) begin
                n_err++; $display("FAIL wide_byte%0d: got %h ok=%0d gap=%0d, expected %h gap 0", j, b, ok, gap, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
        n_cmp++;
        if (sum2 !== 10'(sum_q[0])) begin n_err++; $display("FAIL wide_sum: got %0d, expected %0d", sum2, sum_q[0]); end
        void'(sum_q.pop_front());
    endtask

    task automatic test_relatch();
        logic [7:0] b;
        int gap, v0;
        bit ok;
        latch(0, 1, 2, 1);
        push_msg(0, 5);
        latch(0, 2, 3, 1);
        wait_start(0);
        fork
            rx_frame(0, b, gap, ok);
            begin
                repeat (20) @(negedge clk);
                latch(0, 1, 1, 1);
            end
        join
        n_cmp++;
        if (!ok || b !== exp_q[0]) begin n_err++; $display("FAIL relatch_inflight: got %h ok=%0d, expected %h", b, ok, exp_q[0]); end
        void'(exp_q.pop_front());
        void'(sum_q.pop_front());
        v0 = vld_cnt[0];
        repeat (30) @(negedge clk);
        n_cmp++;
        if (busy[0] !== 1'b0 || vld_cnt[0] != v0) begin
            n_err++; $display("FAIL relatch_wait: busy=%b pulses=%0d, expected 0 0", busy[0], vld_cnt[0] - v0);
        end
        push_msg(0, 8);
        latch(0, 2, 7, 1);
        rx_frame(0, b, gap, ok);
        n_cmp++;
        if (!ok || b !== exp_q[0]) begin n_err++; $display("FAIL relatch_second: got %h ok=%0d, expected %h", b, ok, exp_q[0]); end
        void'(exp_q.pop_front());
        n_cmp++;
        if (sum0 !== 4'(sum_q[0])) begin n_err++; $display("FAIL relatch_sum: got %0d, expected %0d", sum0, sum_q[0]); end
        void'(sum_q.pop_front());
    endtask

    task automatic test_back_to_back();
        logic [7:0] b1, b2;
        int g1, g2, v0;
        bit ok1, ok2;
        latch(0, 1, 3, 1);
        push_msg(0, 6);
        v0 = vld_cnt[0];
        latch(0, 2, 3, 1);
        wait_start(0);
        push_msg(0, 14);
        fork
            begin
                rx_frame(0, b1, g1, ok1);
                n_cmp++;
                if (sum0 !== 4'(sum_q[0])) begin n_err++; $display("FAIL b2b_sum1: got %0d, expected %0d", sum0, sum_q[0]); end
                void'(sum_q.pop_front());
                rx_frame(0, b2, g2, ok2);
            end
            begin
                repeat (4) @(negedge clk);
                latch(0, 3, 7, 60);
            end
        join
        n_cmp++;
        if (!ok1 || b1 !== exp_q[0]) begin n_err++; $display("FAIL b2b_first: got %h ok=%0d, expected %h", b1, ok1, exp_q[0]); end
        void'(exp_q.pop_front());
        n_cmp++;
        if (!ok2 || b2 !== exp_q[0] || g2 != 1) begin
            n_err++; $display("FAIL b2b_second: got %h ok=%0d gap=%0d, expected %h gap 1", b2, ok2, g2, exp_q[0]);
        end
        void'(exp_q.pop_front());
        n_cmp++;
        if (sum0 !== 4'(sum_q[0])) begin n_err++; $display("FAIL b2b_sum2: got %0d, expected %0d", sum0, sum_q[0]); end
        void'(sum_q.pop_front());
        repeat (60) @(negedge clk);
        n_cmp++;
        if (busy[0] !== 1'b0 || vld_cnt[0] - v0 != 2) begin
            n_err++; $display("FAIL b2b_held_strobe: busy=%b pulses=%0d, expected 0 2", busy[0], vld_cnt[0] - v0);
        end
    endtask

    task automatic test_en_gate_reset();
        logic [7:0] b;
        int gap;
        bit ok, quiet;
        en[0] = 1'b0;
        latch(0, 1, 6, 1);
        latch(0, 2, 1, 1);
        quiet = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (busy[0] !== 1'b0 || txd[0] !== 1'b1) quiet = 1'b0;
        end
        n_cmp++;
        if (!quiet) begin n_err++; $display("FAIL gate_quiet: activity with tx_en=0, expected none"); end
        push_msg(0, 7);
        en[0] = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (txd[0] !== 1'b0 || busy[0] !== 1'b1 || vld[0] !== 1'b1) begin
            n_err++; $display("FAIL gate_start: txd=%b busy=%b valid=%b, expected 0 1 1", txd[0], busy[0], vld[0]);
        end
        n_cmp++;
        if (sum0 !== 4'(sum_q[0])) begin n_err++; $display("FAIL gate_sum: got %0d, expected %0d", sum0, sum_q[0]); end
        void'(sum_q.pop_front());
        en[0] = 1'b0;
        rx_frame(0, b, gap, ok);
        n_cmp++;
        if (!ok || b !== exp_q[0] || gap != 0) begin
            n_err++; $display("FAIL gate_no_abort: got %h ok=%0d gap=%0d, expected %h gap 0", b, ok, gap, exp_q[0]);
        end
        void'(exp_q.pop_front());
        latch(0, 3, 2, 1);
        repeat (8) @(negedge clk);
        en[0] = 1'b1;
        @(negedge clk);
        repeat (13) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (txd[0] !== 1'b1 || busy[0] !== 1'b0 || sum0 !== 4'd0) begin
            n_err++; $display("FAIL reset_midframe: txd=%b busy=%b sum=%0d, expected 1 0 0", txd[0], busy[0], sum0);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        quiet = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (busy[0] !== 1'b0 || txd[0] !== 1'b1) quiet = 1'b0;
        end
        n_cmp++;
        if (!quiet) begin n_err++; $display("FAIL reset_no_resume: activity after reset, expected idle"); end
    endtask

    initial begin
        test_reset();
        test_raw_frame();
        test_hex_mode();
        test_wide_sum();
        test_relatch();
        test_back_to_back();
        test_en_gate_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
